// File: rtl/fll_cfg_arbiter.sv
// Round-robin arbiter sharing one four-phase FLL config port between NUM_REQ
// requesters, with ack/lock synchronisers and a per-transaction ack timeout.
module fll_cfg_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   input  logic [NUM_REQ-1:0]    req_wrn_i,
   input  logic [2*NUM_REQ-1:0]  req_add_i,
   input  logic [32*NUM_REQ-1:0] req_data_i,
   output logic [NUM_REQ-1:0]    req_done_o,
   output logic                  req_err_o,
   output logic [31:0]           rdata_o,
   output logic                  fll_req_o,
   output logic                  fll_wrn_o,
   output logic [1:0]            fll_add_o,
   output logic [31:0]           fll_data_o,
   input  logic                  fll_ack_i,
   input  logic [31:0]           fll_r_data_i,
   input  logic                  fll_lock_i,
   output logic                  lock_o,
   output logic                  busy_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
   localparam logic [CNT_W-1:0] TMO_W     = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

   state_t            state, state_nxt;
   logic              ack_meta, ack_s, lock_meta, lock_s;
   logic [IDX_W-1:0]  owner;
   logic [IDX_W-1:0]  win_idx;
   logic              win_vld;
   logic [CNT_W-1:0]  tmo_cnt, cnt_nxt;
   logic              tmo_hit;
   logic              grant, ack_done, tmo_done, enter_idle;
   logic [NUM_REQ-1:0] owner_oh;
   logic [1:0]        add_arr  [NUM_REQ];
   logic [31:0]       data_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign add_arr[g]  = req_add_i[2*g +: 2];
      assign data_arr[g] = req_data_i[32*g +: 32];
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ack_meta  <= 1'b0;
         ack_s     <= 1'b0;
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         ack_meta  <= fll_ack_i;
         ack_s     <= ack_meta;
         lock_meta <= fll_lock_i;
         lock_s    <= lock_meta;
      end
   end

   // Search from owner+1 (mod NUM_REQ); owner doubles as the RR pointer.
   always_comb begin
      logic [IDX_W:0] sum;
      win_vld = 1'b0;
      win_idx = '0;
      sum     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = {1'b0, owner} + (IDX_W+1)'(k);
         if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
         if (!win_vld && req_valid_i[sum[IDX_W-1:0]]) begin
            win_vld = 1'b1;
            win_idx = sum[IDX_W-1:0];
         end
      end
   end

   assign cnt_nxt = tmo_cnt + 1'b1;
   assign tmo_hit = (TIMEOUT != 0) && (cnt_nxt == TMO_W);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_vld) state_nxt = REQ;
         REQ:     if (ack_s || tmo_hit) state_nxt = RELEASE;
         RELEASE: if (!ack_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Ack has priority over a timeout landing in the same cycle.
   always_comb begin
      grant      = (state == IDLE) && win_vld;
      ack_done   = (state == REQ) && ack_s;
      tmo_done   = (state == REQ) && !ack_s && tmo_hit;
      enter_idle = (state != IDLE) && (state_nxt == IDLE);
      owner_oh   = '0;
      owner_oh[owner] = 1'b1;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         fll_req_o  <= 1'b0;
         fll_wrn_o  <= 1'b1;
         fll_add_o  <= 2'd0;
         fll_data_o <= 32'd0;
         req_done_o <= '0;
         req_err_o  <= 1'b0;
         rdata_o    <= 32'd0;
         owner      <= IDX_W'(NUM_REQ-1);
         tmo_cnt    <= '0;
      end else begin
         fll_req_o  <= (state_nxt == REQ);
         req_done_o <= (ack_done || tmo_done) ? owner_oh : '0;
         req_err_o  <= tmo_done;
         if (ack_done && fll_wrn_o) rdata_o <= fll_r_data_i;
         if (grant) begin
            fll_wrn_o  <= req_wrn_i[win_idx];
            fll_add_o  <= add_arr[win_idx];
            fll_data_o <= data_arr[win_idx];
            owner      <= win_idx;
            tmo_cnt    <= '0;
         end else if (enter_idle) begin
            fll_wrn_o  <= 1'b1;
            fll_add_o  <= 2'd0;
            fll_data_o <= 32'd0;
         end
         if (state == REQ) tmo_cnt <= cnt_nxt;
      end
   end

   assign lock_o = lock_s;
   assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_fll_cfg_arbiter.sv
// Scoreboard bench for fll_cfg_arbiter: directed commands, FLL register model,
// monitor checks every done pulse against the queued expectation.
module tb_fll_cfg_arbiter;

   logic        HCLK, HRESETn;
   logic [1:0]  req_valid_i, req_wrn_i;
   logic [3:0]  req_add_i;
   logic [63:0] req_data_i;
   logic [1:0]  req_done_o;
   logic        req_err_o;
   logic [31:0] rdata_o;
   logic        fll_req_o, fll_wrn_o;
   logic [1:0]  fll_add_o;
   logic [31:0] fll_data_o;
   logic        fll_ack_i;
   logic [31:0] fll_r_data_i;
   logic        fll_lock_i, lock_o, busy_o;

   fll_cfg_arbiter #(.NUM_REQ(2), .TIMEOUT(8), .CNT_W(16)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .req_valid_i(req_valid_i), .req_wrn_i(req_wrn_i), .req_add_i(req_add_i),
      .req_data_i(req_data_i), .req_done_o(req_done_o), .req_err_o(req_err_o),
      .rdata_o(rdata_o), .fll_req_o(fll_req_o), .fll_wrn_o(fll_wrn_o),
      .fll_add_o(fll_add_o), .fll_data_o(fll_data_o), .fll_ack_i(fll_ack_i),
      .fll_r_data_i(fll_r_data_i), .fll_lock_i(fll_lock_i), .lock_o(lock_o),
      .busy_o(busy_o)
   );

   typedef struct {logic wrn; logic [1:0] add; logic [31:0] data;} cmd_t;
   typedef struct {int owner; logic err; logic [31:0] rdata;
                   logic wrn; logic [1:0] add; logic [31:0] data;} exp_t;

   cmd_t cq0[$], cq1[$];
   exp_t sb[$];
   int   n_checks = 0, n_fail = 0;
   logic model_en;
   int   glitch_req, glitch_done;

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input int r, input logic wrn, input logic [1:0] add, input logic [31:0] data,
                        input logic err, input logic [31:0] rd);
      cmd_t c;
      exp_t e;
      c.wrn = wrn; c.add = add; c.data = data;
      e.owner = r; e.err = err; e.rdata = rd; e.wrn = wrn; e.add = add; e.data = data;
      if (r == 0) cq0.push_back(c);
      else        cq1.push_back(c);
      sb.push_back(e);
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      @(negedge HCLK);
      while ((sb.size() != 0 || busy_o || cq0.size() != 0 || cq1.size() != 0) && n < max) begin
         @(negedge HCLK);
         n++;
      end
      if (n >= max) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle: timed out after %0d cycles, %0d expected done pulses outstanding", n, sb.size());
      end
   endtask

   task automatic wait_req_rise(input int max, output logic seen);
      int n = 0;
      seen = 1'b0;
      while (n < max && !seen) begin
         @(negedge HCLK);
         if (fll_req_o) seen = 1'b1;
         n++;
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_req_rise: fll_req_o never rose within %0d cycles", max);
      end
   endtask

   // Requesters: hold valid while commands are queued, advance on their done pulse.
   initial begin
      req_valid_i = '0; req_wrn_i = '1; req_add_i = '0; req_data_i = '0;
      forever begin
         @(posedge HCLK);
         #1;
         if (req_done_o[0] && cq0.size() > 0) void'(cq0.pop_front());
         if (req_done_o[1] && cq1.size() > 0) void'(cq1.pop_front());
         if (cq0.size() > 0) begin
            req_valid_i[0] = 1'b1; req_wrn_i[0] = cq0[0].wrn;
            req_add_i[1:0] = cq0[0].add; req_data_i[31:0] = cq0[0].data;
         end else req_valid_i[0] = 1'b0;
         if (cq1.size() > 0) begin
            req_valid_i[1] = 1'b1; req_wrn_i[1] = cq1[0].wrn;
            req_add_i[3:2] = cq1[0].add; req_data_i[63:32] = cq1[0].data;
         end else req_valid_i[1] = 1'b0;
      end
   end

   // FLL model: four registers, ack 3 cycles after req, drop ack after req falls.
   initial begin
      logic [31:0] mregs [4];
      int mcnt;
      mregs[0] = 32'h0; mregs[1] = 32'h12345678; mregs[2] = 32'hCAFEF00D; mregs[3] = 32'h0BADF00D;
      mcnt = 0; fll_ack_i = 1'b0; fll_r_data_i = 32'h0; glitch_done = 0;
      forever begin
         @(posedge HCLK);
         #1;
         if (glitch_req != glitch_done) begin
            glitch_done = glitch_req;
            fll_ack_i = 1'b1;
            #2 fll_ack_i = 1'b0;
         end else if (!model_en) begin
            mcnt = 0;
         end else if (fll_req_o && !fll_ack_i) begin
            mcnt++;
            if (mcnt >= 3) begin
               if (!fll_wrn_o) mregs[fll_add_o] = fll_data_o;
               fll_r_data_i = mregs[fll_add_o];
               fll_ack_i = 1'b1;
            end
         end else if (!fll_req_o) begin
            fll_ack_i = 1'b0;
            mcnt = 0;
         end
      end
   end

   // Monitor: every done pulse must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge HCLK);
         if (HRESETn && req_done_o != 2'b00) begin
            if (sb.size() == 0) check("unexpected_done", 32'(req_done_o), 32'h0);
            else begin
               e = sb.pop_front();
               check("done_vec", 32'(req_done_o), 32'(1) << e.owner);
               check("done_err", 32'(req_err_o), 32'(e.err));
               check("done_rdata", rdata_o, e.rdata);
               check("done_fll_wrn", 32'(fll_wrn_o), 32'(e.wrn));
               check("done_fll_add", 32'(fll_add_o), 32'(e.add));
               check("done_fll_data", fll_data_o, e.data);
               check("done_fll_req_low", 32'(fll_req_o), 32'h0);
            end
         end
      end
   end

   initial begin
      logic seen;
      int   cnt;
      HRESETn = 1'b0; fll_lock_i = 1'b0; model_en = 1'b1; glitch_req = 0;
      repeat (3) @(negedge HCLK);
      check("rst_fll_req", 32'(fll_req_o), 32'h0);
      check("rst_fll_wrn", 32'(fll_wrn_o), 32'h1);
      check("rst_fll_add", 32'(fll_add_o), 32'h0);
      check("rst_fll_data", fll_data_o, 32'h0);
      check("rst_done", 32'(req_done_o), 32'h0);
      check("rst_err", 32'(req_err_o), 32'h0);
      check("rst_rdata", rdata_o, 32'h0);
      check("rst_lock", 32'(lock_o), 32'h0);
      check("rst_busy", 32'(busy_o), 32'h0);

      // Both requesters valid from reset: grants 0,1,0,1.
      issue(0, 1'b0, 2'd0, 32'h11110000, 1'b0, 32'h0);
      issue(1, 1'b0, 2'd3, 32'h33330003, 1'b0, 32'h0);
      issue(0, 1'b1, 2'd0, 32'h0, 1'b0, 32'h11110000);
      issue(1, 1'b1, 2'd3, 32'h0, 1'b0, 32'h33330003);
      @(negedge HCLK);
      HRESETn = 1'b1;
      wait_idle(300);

      issue(0, 1'b0, 2'd2, 32'hDEADBEEF, 1'b0, 32'h33330003);
      wait_idle(100);
      check("idle_fll_wrn", 32'(fll_wrn_o), 32'h1);
      check("idle_fll_add", 32'(fll_add_o), 32'h0);
      check("idle_fll_data", fll_data_o, 32'h0);
      check("idle_fll_req", 32'(fll_req_o), 32'h0);

      issue(1, 1'b1, 2'd1, 32'h0, 1'b0, 32'h12345678);
      wait_idle(100);

      // Dead FLL with a short ack glitch: requester 0 times out, then 1 is served.
      model_en = 1'b0;
      issue(0, 1'b0, 2'd1, 32'h55555555, 1'b1, 32'h12345678);
      issue(1, 1'b1, 2'd2, 32'h0, 1'b0, 32'hDEADBEEF);
      wait_req_rise(20, seen);
      cnt = 0;
      while (seen && fll_req_o && cnt < 50) begin
         cnt++;
         if (cnt == 3) glitch_req++;
         @(negedge HCLK);
      end
      check("tmo_req_cycles", 32'(cnt), 32'd8);
      model_en = 1'b1;
      wait_idle(100);

      // Reset in REQ: request drops at once, no done, requester 0 wins again.
      issue(0, 1'b0, 2'd0, 32'h0F0F0F0F, 1'b0, 32'h0);
      issue(1, 1'b1, 2'd2, 32'h0, 1'b0, 32'hDEADBEEF);
      wait_req_rise(20, seen);
      @(negedge HCLK);
      #2 HRESETn = 1'b0;
      #1;
      check("arst_fll_req", 32'(fll_req_o), 32'h0);
      check("arst_busy", 32'(busy_o), 32'h0);
      repeat (2) begin
         @(negedge HCLK);
         check("arst_no_done", 32'(req_done_o), 32'h0);
      end
      HRESETn = 1'b1;
      wait_idle(200);

      // Lock synchroniser latency.
      @(posedge HCLK);
      #1 fll_lock_i = 1'b1;
      @(negedge HCLK);
      check("lock_edge0", 32'(lock_o), 32'h0);
      @(negedge HCLK);
      check("lock_edge1", 32'(lock_o), 32'h0);
      @(negedge HCLK);
      check("lock_edge2", 32'(lock_o), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
